mem_arbiter: RTL and testbench

//  Two-requester round-robin arbiter and sequencer in front of one single-port memory
//  (sync write, async read, ports we/clk/addr/write/read). Serialises port A / port B

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 25 ++
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port round-robin memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    localparam int STAT_W = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant logic: on a tie the port that was not served last wins.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic    req_a,
    input  logic    req_b,
    input  req_id_t last_id,
    output logic    gnt_a,
    output logic    gnt_b
);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (req_a && req_b) begin
            if (last_id == REQ_B) gnt_a = 1'b1;
            else                  gnt_b = 1'b1;
        end else begin
            gnt_a = req_a;
            gnt_b = req_b;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sequencer of port A/B reads and writes onto one single-port memory.
// Define MEM_ARB_STATS_EN to add saturating per-port grant counters (a_count, b_count).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N      = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [N-1:0]      a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [N-1:0]      a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [N-1:0]      b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [N-1:0]      b_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [N-1:0]      mem_write,
    input  logic [N-1:0]      mem_read
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] a_count,
    output logic [STAT_W-1:0] b_count
`endif
);

    arb_state_t        state_q, state_d;
    req_id_t           last_id_q, last_id_d;
    req_id_t           id_q, id_d;
    logic              op_we_q, op_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [N-1:0]      wdata_q, wdata_d;
    logic [N-1:0]      a_rdata_q, a_rdata_d;
    logic [N-1:0]      b_rdata_q, b_rdata_d;
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic              arb_gnt_a, arb_gnt_b;

    rr_arbiter2 u_rr (
        .req_a   (a_req),
        .req_b   (b_req),
        .last_id (last_id_q),
        .gnt_a   (arb_gnt_a),
        .gnt_b   (arb_gnt_b)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (a_gnt || b_gnt) state_d = ACCESS;
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset forces IDLE asynchronously, so mem_we drops without waiting for an edge.
    always_comb begin
        a_gnt  = (state_q == IDLE) && arb_gnt_a;
        b_gnt  = (state_q == IDLE) && arb_gnt_b;
        mem_we = (state_q == ACCESS) && op_we_q;
    end

    always_comb begin
        last_id_d  = last_id_q;
        id_d       = id_q;
        op_we_d    = op_we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        if (a_gnt) begin
            id_d      = REQ_A;
            last_id_d = REQ_A;
            op_we_d   = a_we;
            addr_d    = a_addr;
            wdata_d   = a_wdata;
        end else if (b_gnt) begin
            id_d      = REQ_B;
            last_id_d = REQ_B;
            op_we_d   = b_we;
            addr_d    = b_addr;
            wdata_d   = b_wdata;
        end
        if (state_q == ACCESS && !op_we_q) begin
            if (id_q == REQ_A) begin
                a_rdata_d  = mem_read;
                a_rvalid_d = 1'b1;
            end else begin
                b_rdata_d  = mem_read;
                b_rvalid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_id_q  <= REQ_B;
            id_q       <= REQ_A;
            op_we_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            last_id_q  <= last_id_d;
            id_q       <= id_d;
            op_we_q    <= op_we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_write = wdata_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;

`ifdef MEM_ARB_STATS_EN
    logic [STAT_W-1:0] a_count_q, a_count_d;
    logic [STAT_W-1:0] b_count_q, b_count_d;

    always_comb begin
        a_count_d = a_count_q;
        b_count_d = b_count_q;
        if (a_gnt && a_count_q != '1) a_count_d = a_count_q + 1'b1;
        if (b_gnt && b_count_q != '1) b_count_d = b_count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_count_q <= '0;
            b_count_q <= '0;
        end else begin
            a_count_q <= a_count_d;
            b_count_q <= b_count_d;
        end
    end

    assign a_count = a_count_q;
    assign b_count = b_count_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory, reference memory and per-port read scoreboards.
module tb_mem_arbiter;

    localparam int N  = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [N-1:0]  a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [N-1:0]  a_rdata, b_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_write, mem_read;
`ifdef MEM_ARB_STATS_EN
    logic [15:0]   a_count, b_count;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.N(N), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_read  (mem_read)
`ifdef MEM_ARB_STATS_EN
        ,
        .a_count   (a_count),
        .b_count   (b_count)
`endif
    );

    // Behavioural single-port memory: synchronous write, asynchronous read.
    logic [N-1:0] mem [256] = '{default: 8'h00};
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_write;
    assign mem_read = mem[mem_addr];

    // Reference contents, updated at grant time in grant order.
    logic [N-1:0] ref_mem [256] = '{default: 8'h00};

    typedef struct {
        logic [N-1:0] data;
        int           gcyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   grant_log[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   a_rv_cnt = 0;
    int   b_rv_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge; issues one request, waits for the grant, returns at a falling edge.
    task automatic do_op(input bit port, input bit we, input logic [AW-1:0] addr,
                         input logic [N-1:0] wd, output int gcyc);
        int waited = 0;
        bit got    = 1'b0;
        exp_t e;
        gcyc = -1;
        if (!port) begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
        else       begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
        while (!got && waited < 50) begin
            #1;
            if ((port ? b_gnt : a_gnt) === 1'b1) got = 1'b1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
        if (!got) check(port ? "b_gnt_timeout" : "a_gnt_timeout", 0, 1);
        else begin
            gcyc = cyc;
            grant_log.push_back(int'(port));
            if (we) ref_mem[addr] = wd;
            else begin
                e.data = ref_mem[addr];
                e.gcyc = cyc;
                if (!port) qa.push_back(e);
                else       qb.push_back(e);
            end
        end
        @(negedge clk);
        if (!port) a_req = 1'b0;
        else       b_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Output monitor: one-hot grants and read-data scoreboard, sampled after the falling edge.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst) begin
            if (a_gnt || b_gnt) check("gnt_onehot", {31'd0, a_gnt & b_gnt}, 0);
            if (a_rvalid) begin
                a_rv_cnt++;
                if (qa.size() == 0) check("a_rvalid_unexpected", 1, 0);
                else begin
                    e = qa.pop_front();
                    check("a_rdata", {24'd0, a_rdata}, {24'd0, e.data});
                    check("a_rlatency", cyc - e.gcyc, 2);
                end
            end
            if (b_rvalid) begin
                b_rv_cnt++;
                if (qb.size() == 0) check("b_rvalid_unexpected", 1, 0);
                else begin
                    e = qb.pop_front();
                    check("b_rdata", {24'd0, b_rdata}, {24'd0, e.data});
                    check("b_rlatency", cyc - e.gcyc, 2);
                end
            end
        end
    end

    initial begin
        int g1, g2, g3, g4, b_before;
        int prev;
        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

        #3;
        check("rst_mem_we", {31'd0, mem_we}, 0);
        check("rst_a_gnt", {31'd0, a_gnt}, 0);
        check("rst_b_gnt", {31'd0, b_gnt}, 0);
        check("rst_a_rvalid", {31'd0, a_rvalid}, 0);
        check("rst_b_rvalid", {31'd0, b_rvalid}, 0);
        check("rst_mem_addr", {24'd0, mem_addr}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // A write then A read; B must stay silent.
        b_before = b_rv_cnt;
        do_op(1'b0, 1'b1, 8'h05, 8'h3C, g1);
        do_op(1'b0, 1'b0, 8'h05, 8'h00, g2);
        check("t2_gnt_gap", g2 - g1, 2);
        repeat (3) @(negedge clk);
        check("t2_b_quiet", b_rv_cnt - b_before, 0);
        check("t2_a_rdata_hold", {24'd0, a_rdata}, 32'h3C);
        do_op(1'b1, 1'b0, 8'h05, 8'h00, g1);
        repeat (3) @(negedge clk);

        // Reset in the middle of a write access.
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = 8'hAA;
        #1;
        check("t1_gnt", {31'd0, a_gnt}, 1);
        @(negedge clk);
        a_req = 1'b0;
        #1;
        check("t1_we_before_rst", {31'd0, mem_we}, 1);
        rst = 1'b1;
        #1;
        check("t1_mem_we", {31'd0, mem_we}, 0);
        check("t1_mem_addr", {24'd0, mem_addr}, 0);
        check("t1_mem_write", {24'd0, mem_write}, 0);
        check("t1_a_rdata", {24'd0, a_rdata}, 0);
        check("t1_b_rdata", {24'd0, b_rdata}, 0);
        check("t1_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
        @(negedge clk);
        rst = 1'b0;
        check("t1_no_commit", {31'd0, mem[8'h10] == 8'hAA}, 0);
        do_op(1'b0, 1'b0, 8'h10, 8'h00, g1);
        repeat (3) @(negedge clk);

        // Contention: both ports read continuously after reset, expect A,B,A,B.
        do_op(1'b0, 1'b1, 8'h01, 8'h11, g1);
        do_op(1'b1, 1'b1, 8'h02, 8'h22, g1);
        do_reset();
        grant_log.delete();
        fork
            begin
                do_op(1'b0, 1'b0, 8'h01, 8'h00, g1);
                do_op(1'b0, 1'b0, 8'h01, 8'h00, g2);
            end
            begin
                do_op(1'b1, 1'b0, 8'h02, 8'h00, g3);
                do_op(1'b1, 1'b0, 8'h02, 8'h00, g4);
            end
        join
        check("t3_nlog", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            check("t3_order0", grant_log[0], 0);
            check("t3_order1", grant_log[1], 1);
            check("t3_order2", grant_log[2], 0);
            check("t3_order3", grant_log[3], 1);
        end
        repeat (3) @(negedge clk);

        // B alone, continuous: a grant every second cycle.
        prev = -1;
        for (int i = 0; i < 5; i++) begin
            do_op(1'b1, 1'b0, 8'(i + 1), 8'h00, g1);
            if (prev >= 0) check("t4_b_gap", g1 - prev, 2);
            prev = g1;
        end
        repeat (3) @(negedge clk);

        // Full address sweep: write via A, read back via B.
        for (int i = 0; i < 256; i++) begin
            do_op(1'b0, 1'b1, 8'(i), 8'(i), g1);
            do_op(1'b1, 1'b0, 8'(i), 8'h00, g2);
        end
        repeat (3) @(negedge clk);

`ifdef MEM_ARB_STATS_EN
        do_reset();
        check("st_a_zero", {16'd0, a_count}, 0);
        for (int i = 0; i < 3; i++) do_op(1'b0, 1'b1, 8'h40, 8'(i), g1);
        for (int i = 0; i < 5; i++) do_op(1'b1, 1'b1, 8'h41, 8'(i), g1);
        check("st_a_count", {16'd0, a_count}, 3);
        check("st_b_count", {16'd0, b_count}, 5);
        b_req = 1'b1; b_we = 1'b1; b_addr = 8'hFF; b_wdata = 8'h00;
        repeat (140010) @(negedge clk);
        b_req = 1'b0;
        ref_mem[8'hFF] = 8'h00;
        check("st_b_sat", {16'd0, b_count}, 32'hFFFF);
        check("st_a_hold", {16'd0, a_count}, 3);
`endif

        for (int i = 0; i < 10 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
        check("drain_qa", qa.size(), 0);
        check("drain_qb", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
